// File: rtl/ctrl_stage_pipe.sv
// Generic E/M/W control-bundle carrier with per-stage stall, flush and bubbles.
// Optional perf counters (bubble_cnt, flush_cnt) enabled by CTRL_PIPE_PERF_EN.
module ctrl_stage_pipe #(
  parameter int CTRL_W = 16,
  parameter int EXC_W = 4,
  parameter int STAGES = 3,
  parameter logic [CTRL_W-1:0] KILL_MASK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        ctrl_d,
  input  logic [EXC_W-1:0]         exc_d,
  input  logic                     valid_d,
  input  logic                     stall_d,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES*CTRL_W-1:0] ctrl_q,
  output logic [STAGES*EXC_W-1:0]  exc_q,
  output logic [STAGES-1:0]        valid_q,
  output logic [STAGES-1:0]        exc_any_q
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]              bubble_cnt,
  output logic [31:0]              flush_cnt
`endif
);

`ifdef CTRL_PIPE_PERF_EN
  logic [STAGES-1:0] bub_ev;
  logic [STAGES-1:0] fl_ev;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [CTRL_W-1:0] ctrl_r;
    logic [EXC_W-1:0]  exc_r;
    logic              valid_r;
    logic              exc_any_r;

    logic [CTRL_W-1:0] up_ctrl;
    logic [EXC_W-1:0]  up_exc;
    logic              up_valid;
    logic              up_stall;

    if (i == 0) begin : g_head
      assign up_ctrl  = ctrl_d;
      assign up_exc   = exc_d;
      assign up_valid = valid_d;
      assign up_stall = stall_d;
    end else begin : g_link
      assign up_ctrl  = g_stage[i-1].ctrl_r;
      assign up_exc   = g_stage[i-1].exc_r;
      assign up_valid = g_stage[i-1].valid_r;
      assign up_stall = stall[i-1];
    end

    logic              up_exc_any;
    logic [CTRL_W-1:0] load_ctrl;
    assign up_exc_any = |up_exc;
    assign load_ctrl  = up_ctrl & ~(up_exc_any ? KILL_MASK : '0);

    // Invalid upstream loads as an empty bundle so valid=0 implies ctrl=0, exc=0.
    always_ff @(posedge clk) begin
      if (rst || flush[i]) begin
        ctrl_r    <= '0;
        exc_r     <= '0;
        valid_r   <= 1'b0;
        exc_any_r <= 1'b0;
      end else if (!stall[i]) begin
        if (up_stall || !up_valid) begin
          ctrl_r    <= '0;
          exc_r     <= '0;
          valid_r   <= 1'b0;
          exc_any_r <= 1'b0;
        end else begin
          ctrl_r    <= load_ctrl;
          exc_r     <= up_exc;
          valid_r   <= 1'b1;
          exc_any_r <= up_exc_any;
        end
      end
    end

    assign ctrl_q[i*CTRL_W +: CTRL_W] = ctrl_r;
    assign exc_q[i*EXC_W +: EXC_W]    = exc_r;
    assign valid_q[i]                 = valid_r;
    assign exc_any_q[i]               = exc_any_r;

`ifdef CTRL_PIPE_PERF_EN
    assign bub_ev[i] = !flush[i] && !stall[i] && up_stall && up_valid;
    assign fl_ev[i]  = flush[i] && valid_r;
`endif
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [32:0] bub_sum;
  logic [32:0] fl_sum;

  always_comb begin
    bub_sum = {1'b0, bubble_cnt} + 33'($countones(bub_ev));
    fl_sum  = {1'b0, flush_cnt} + 33'($countones(fl_ev));
  end

  // Carry-out means overflow: pin at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= bub_sum[32] ? '1 : bub_sum[31:0];
      flush_cnt  <= fl_sum[32] ? '1 : fl_sum[31:0];
    end
  end
`endif

endmodule
